// File: rtl/sirv_gnrl_fifo.sv
// Synchronous valid/ready FIFO with DP entries of DW bits and a registered occupancy count.
// Storage has no reset; only the pointers and the count are cleared.
module sirv_gnrl_fifo #(
   parameter int DW        = 32,
   parameter int DP        = 4,
   parameter int CUT_READY = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_vld,
   output logic                       i_rdy,
   input  logic [DW-1:0]              i_dat,
   output logic                       o_vld,
   input  logic                       o_rdy,
   output logic [DW-1:0]              o_dat,
   output logic [$clog2(DP+1)-1:0]    count
);

   localparam int PW = (DP > 1) ? $clog2(DP) : 1;
   localparam int CW = $clog2(DP + 1);

   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   logic [DW-1:0] r_mem [DP];

   logic w_full;
   logic w_empty;
   logic w_push;
   logic w_pop;
   logic w_rdyRaw;

   // Wraps DP-1 back to 0 so non-power-of-two depths never reach unused slots.
   function automatic logic [PW-1:0] incPtr(input logic [PW-1:0] p);
      return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_full  = (r_count == CW'(DP));
   assign w_empty = (r_count == '0);

   // When full, wptr equals rptr, so a same-cycle push lands in the slot being vacated.
   generate
      if (CUT_READY != 0) begin : g_cut
         assign w_rdyRaw = !w_full;
      end else begin : g_nocut
         assign w_rdyRaw = !w_full | o_rdy;
      end
   endgenerate

   assign i_rdy  = !reset & w_rdyRaw;
   assign o_vld  = !reset & !w_empty;
   assign w_push = i_vld & i_rdy;
   assign w_pop  = o_vld & o_rdy;
   assign o_dat  = r_mem[r_rptr];
   assign count  = r_count;

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= incPtr(r_wptr);
         end
         if (w_pop) begin
            r_rptr <= incPtr(r_rptr);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sirv_gnrl_fifo.sv
// Bench for sirv_gnrl_fifo: nine instances over several depths and ready modes, driven by
// a vector table, directed corner sequences and a randomized run against a queue model.
module tb_sirv_gnrl_fifo;

   function automatic int dpOf(input int g);
      case (g)
         0, 1:    return 4;
         2:       return 3;
         3, 4:    return 1;
         5, 6:    return 2;
         default: return 5;
      endcase
   endfunction

   function automatic int cutOf(input int g);
      return (g == 1 || g == 4 || g == 6 || g == 8) ? 1 : 0;
   endfunction

   logic        clk;
   logic        reset;
   logic        iVld [9];
   logic        iRdy [9];
   logic [31:0] iDat [9];
   logic        oVld [9];
   logic        oRdy [9];
   logic [31:0] oDat [9];
   logic [3:0]  cnt  [9];

   int checks = 0;
   int errors = 0;

   for (genvar g = 0; g < 9; g++) begin : g_dut
      localparam int GDP  = dpOf(g);
      localparam int GCUT = cutOf(g);
      logic [$clog2(GDP+1)-1:0] wCnt;
      sirv_gnrl_fifo #(.DW(32), .DP(GDP), .CUT_READY(GCUT)) u_dut (
         .clk   (clk),
         .reset (reset),
         .i_vld (iVld[g]),
         .i_rdy (iRdy[g]),
         .i_dat (iDat[g]),
         .o_vld (oVld[g]),
         .o_rdy (oRdy[g]),
         .o_dat (oDat[g]),
         .count (wCnt)
      );
      assign cnt[g] = 4'(wCnt);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          vld;
      bit          ordy;
      logic [31:0] dat;
      bit          eIRdy;
      bit          eOVld;
      logic [31:0] eODat;
      int          eCnt;
   } vec_t;

   vec_t vecs [10];

   logic [31:0] mData [9][1024];
   int          mPush [9];
   int          mPop  [9];

   task automatic compare(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s dut=%0d actual=%0h required=%0h", name, idx, act, exp);
      end
   endtask

   task automatic applyStimulus(input int idx, input bit vld, input logic [31:0] dat, input bit ordy);
      iVld[idx] = vld;
      iDat[idx] = dat;
      oRdy[idx] = ordy;
   endtask

   task automatic checkOutput(input int idx, input string name, input bit eIRdy, input bit eOVld,
                              input logic [31:0] eODat, input int eCnt);
      compare({name, ".i_rdy"}, idx, 32'(iRdy[idx]), 32'(eIRdy));
      compare({name, ".o_vld"}, idx, 32'(oVld[idx]), 32'(eOVld));
      if (eOVld) begin
         compare({name, ".o_dat"}, idx, oDat[idx], eODat);
      end
      compare({name, ".count"}, idx, 32'(cnt[idx]), 32'(eCnt));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] vals [4];
      int          sz;
      bit          v;
      bit          r;
      bit          eR;
      bit          eV;
      logic [31:0] d;

      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

      vecs[0] = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b0, 32'h0,  0};
      vecs[1] = '{1'b1, 1'b0, 32'h22, 1'b1, 1'b1, 32'h11, 1};
      vecs[2] = '{1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 32'h11, 2};
      vecs[3] = '{1'b1, 1'b0, 32'h44, 1'b1, 1'b1, 32'h11, 3};
      vecs[4] = '{1'b0, 1'b0, 32'h0,  1'b0, 1'b1, 32'h11, 4};
      vecs[5] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'h11, 4};
      vecs[6] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'h22, 3};
      vecs[7] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'h33, 2};
      vecs[8] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b1, 32'h44, 1};
      vecs[9] = '{1'b0, 1'b1, 32'h0,  1'b1, 1'b0, 32'h0,  0};

      reset = 1'b1;
      for (int g = 0; g < 9; g++) applyStimulus(g, 1'b0, 32'h0, 1'b0);
      tick();
      for (int g = 0; g < 9; g++) begin
         compare("rst.i_rdy", g, 32'(iRdy[g]), 32'h0);
         compare("rst.o_vld", g, 32'(oVld[g]), 32'h0);
      end
      tick();
      reset = 1'b0;
      #1;
      for (int g = 0; g < 9; g++) checkOutput(g, "postrst", 1'b1, 1'b0, 32'h0, 0);

      // Fill then drain on the DP=4 instance that allows push-at-full with pop.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, vecs[i].vld, vecs[i].dat, vecs[i].ordy);
         #1;
         checkOutput(0, "filldrain", vecs[i].eIRdy, vecs[i].eOVld, vecs[i].eODat, vecs[i].eCnt);
         tick();
      end

      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1'b1, vals[k], 1'b0);
         applyStimulus(1, 1'b1, vals[k], 1'b0);
         tick();
      end
      applyStimulus(0, 1'b1, 32'h55, 1'b1);
      applyStimulus(1, 1'b1, 32'h55, 1'b1);
      #1;
      checkOutput(0, "fullsim", 1'b1, 1'b1, 32'h11, 4);
      checkOutput(1, "fullsim", 1'b0, 1'b1, 32'h11, 4);
      tick();
      applyStimulus(0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1, 1'b1, 32'h55, 1'b0);
      #1;
      checkOutput(0, "fullhold", 1'b0, 1'b1, 32'h22, 4);
      checkOutput(1, "fullretry", 1'b1, 1'b1, 32'h22, 3);
      tick();
      for (int k = 0; k < 4; k++) begin
         applyStimulus(0, 1'b0, 32'h0, 1'b1);
         applyStimulus(1, 1'b0, 32'h0, 1'b1);
         #1;
         d = (k == 3) ? 32'h55 : vals[k + 1];
         checkOutput(0, "fulldrain", 1'b1, 1'b1, d, 4 - k);
         checkOutput(1, "fulldrain", k != 0, 1'b1, d, 4 - k);
         tick();
      end
      applyStimulus(0, 1'b0, 32'h0, 1'b0);
      applyStimulus(1, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput(0, "fullempty", 1'b1, 1'b0, 32'h0, 0);
      checkOutput(1, "fullempty", 1'b1, 1'b0, 32'h0, 0);

      // Streaming through DP=3 exercises the 2->0 pointer wrap several times.
      applyStimulus(2, 1'b1, 32'd1, 1'b0);
      #1;
      checkOutput(2, "wrap", 1'b1, 1'b0, 32'h0, 0);
      tick();
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(2, k < 10, 32'(k + 1), 1'b1);
         #1;
         checkOutput(2, "wrap", 1'b1, 1'b1, 32'(k), 1);
         tick();
      end
      applyStimulus(2, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput(2, "wrapend", 1'b1, 1'b0, 32'h0, 0);

      applyStimulus(0, 1'b1, 32'hA5, 1'b1);
      #1;
      checkOutput(0, "nobypass", 1'b1, 1'b0, 32'h0, 0);
      tick();
      applyStimulus(0, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput(0, "nobypass", 1'b1, 1'b1, 32'hA5, 1);
      tick();
      #1;
      checkOutput(0, "nobypass", 1'b1, 1'b0, 32'h0, 0);

      applyStimulus(0, 1'b1, 32'h01, 1'b0);
      tick();
      applyStimulus(0, 1'b1, 32'h02, 1'b0);
      tick();
      applyStimulus(0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput(0, "preRst", 1'b1, 1'b1, 32'h01, 2);
      reset = 1'b1;
      applyStimulus(0, 1'b1, 32'h03, 1'b0);
      #1;
      compare("midrst.i_rdy", 0, 32'(iRdy[0]), 32'h0);
      compare("midrst.o_vld", 0, 32'(oVld[0]), 32'h0);
      tick();
      reset = 1'b0;
      applyStimulus(0, 1'b0, 32'h0, 1'b0);
      #1;
      checkOutput(0, "afterRst", 1'b1, 1'b0, 32'h0, 0);
      tick();
      applyStimulus(0, 1'b1, 32'h03, 1'b0);
      tick();
      applyStimulus(0, 1'b0, 32'h0, 1'b1);
      #1;
      checkOutput(0, "afterRstPush", 1'b1, 1'b1, 32'h03, 1);
      tick();
      applyStimulus(0, 1'b0, 32'h0, 1'b0);

      for (int g = 0; g < 9; g++) begin
         mPush[g] = 0;
         mPop[g]  = 0;
      end
      for (int c = 0; c < 1000; c++) begin
         for (int g = 3; g < 9; g++) begin
            applyStimulus(g, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)));
         end
         #1;
         for (int g = 3; g < 9; g++) begin
            v  = iVld[g];
            r  = oRdy[g];
            d  = iDat[g];
            sz = mPush[g] - mPop[g];
            eR = (sz < dpOf(g)) || (cutOf(g) == 0 && r);
            eV = (sz > 0);
            checkOutput(g, "rand", eR, eV, mData[g][mPop[g] % 1024], sz);
            if (v && eR) begin
               mData[g][mPush[g] % 1024] = d;
               mPush[g]++;
            end
            if (eV && r) mPop[g]++;
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sirv_gnrl_fifo.md
# sirv_gnrl_fifo

Synchronous valid/ready FIFO assembled from the general DFF primitives (load-enabled data registers, reset-bearing control registers). It decouples a producer stage from a consumer stage in the SoC datapath, absorbing back-pressure for up to DP entries. It sits directly downstream of flop-based pipeline registers and feeds any valid/ready consumer.

## Interface
- DW, 32, data width in bits (≥1)
- DP, 4, depth in entries (≥1, any integer, not restricted to powers of two)
- CUT_READY, 0, 1 = i_rdy depends only on internal state (no o_rdy→i_rdy combinational path); 0 = i_rdy also asserts when full and o_rdy=1
- clk  input  1  single clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- i_vld  input  1  producer has data
- i_rdy  output  1  FIFO accepts data this cycle
- i_dat  input  DW  write data
- o_vld  output  1  FIFO head valid
- o_rdy  input  1  consumer takes head this cycle
- o_dat  output  DW  head data
- count  output  $clog2(DP+1)  number of occupied entries

## Operation
- push = i_vld & i_rdy; pop = o_vld & o_rdy. Both evaluated in same cycle, independently.
- Storage: DP entries of DW bits, load-enabled only on push at wptr; no reset on storage.
- Control state (reset-bearing): wptr, rptr (range 0..DP-1), count (0..DP).
- wptr advances on push, rptr on pop; each wraps DP-1 → 0. DP=1: pointers constant 0.
- count_next = count + push − pop; push&pop together leaves count unchanged.
- full = (count==DP); empty = (count==0).
- o_vld = !empty; o_dat = entry[rptr] (combinational read). o_dat is don't-care while o_vld=0.
- i_rdy: CUT_READY=1 → !full. CUT_READY=0 → !full | o_rdy (push into a full FIFO permitted only when a pop happens the same cycle; write lands in slot being vacated, since wptr==rptr when full).
- No bypass: data pushed into an empty FIFO is not visible at o_dat the same cycle.
- Order strictly preserved; no data lost or duplicated under any i_vld/o_rdy pattern.
- i_vld with i_rdy=0: no state change; producer must hold i_dat stable (handshake rule, not checked by block).
- o_vld, once high, stays high until a pop (never retracted).

## Timing
- Reset (reset=1 at rising edge): next cycle wptr=0, rptr=0, count=0, o_vld=0. While reset is high, i_rdy=0 and o_vld=0 combinationally; any push/pop that cycle is ignored.
- Reset mid-operation: all stored entries discarded; storage contents unchanged but unreachable; first cycle after reset deasserts: count=0, o_vld=0, i_rdy=1.
- Latency: push at edge N → o_vld=1, o_dat=pushed data in cycle after N (1 cycle minimum input-to-output).
- Throughput: 1 transfer/cycle sustained in both directions when 0<count<DP; at full, 1/cycle only with CUT_READY=0.
- With CUT_READY=1 and DP=1: alternate-cycle throughput (full blocks push while pop pending) — accepted behaviour.
- count updates registered, valid from cycle after the handshake.

## Test plan
- Fill/drain, DP=4, DW=32, o_rdy=0: push 0x11,0x22,0x33,0x44 on 4 consecutive cycles → count 1,2,3,4, i_rdy=0 after 4th; then o_rdy=1 → o_dat 0x11,0x22,0x33,0x44 on consecutive cycles, o_vld=0 and count=0 afterwards.
- Simultaneous at full: FIFO full (DP=4), i_vld=1, o_rdy=1 → CUT_READY=0: i_rdy=1, pop 0x11 and push 0x55 same cycle, count stays 4, later drain order 0x22,0x33,0x44,0x55; CUT_READY=1: i_rdy=0, count drops to 3, 0x55 accepted next cycle.
- Wrap-around, DP=3: stream 10 values 1..10 with i_vld=1, o_rdy=1 after one-cycle head start → output 1..10 in order, count never exceeds 3, pointers wrap 2→0 without gap.
- Empty pop / no bypass: empty FIFO, o_rdy=1, push 0xA5 → o_vld=0 same cycle, o_vld=1 with 0xA5 next cycle, count 0→1→0.
- Reset mid-operation: count=2 holding 0x01,0x02, assert reset one cycle with i_vld=1 → i_rdy=0 and o_vld=0 during reset; after, count=0, o_vld=0; push 0x03 → first output 0x03.
- Random back-pressure: 1000 cycles, random i_vld/o_rdy (50%), both CUT_READY values, DP∈{1,2,5} → scoreboard matches in-order, count equals pushes−pops every cycle, o_vld never drops without pop.
